// File: rtl/ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// ram_access_ctrl
//   Command stage in front of a single-port synchronous RAM. A write or read
//   command is taken over a valid/ready handshake and turned into the RAM
//   control pin sequence. Read data is captured after a fixed pipeline
//   latency, parity-checked and returned over a response handshake. Only one
//   command is in flight at a time.
//
// Ports
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_wr, cmd_addr, cmd_data      command payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready             read response handshake
//   rsp_data, rsp_perr              read data and its parity-mismatch flag
//   perr_count                      saturating count of parity mismatches
//   ram_blk_sel, ram_addr_en,
//   ram_wr_en, ram_rd_en,
//   ram_dout_en, ram_addr, ram_din  RAM control/address/data pins (registered)
//   ram_dout, ram_parity            RAM read data and its parity pin
// -----------------------------------------------------------------------------
module ram_access_ctrl #(
  parameter int MEM_WIDTH    = 16,
  parameter int ADDR_SIZE    = 10,
  parameter int RD_LATENCY   = 2,
  parameter int PARITY_CHECK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [MEM_WIDTH-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MEM_WIDTH-1:0] rsp_data,
  output logic                 rsp_perr,
  output logic [7:0]           perr_count,
  output logic                 ram_blk_sel,
  output logic                 ram_addr_en,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_dout_en,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_parity
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // WAIT lasts RD_LATENCY cycles: the counter counts down to zero inclusive.
  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_lat_cnt;

  logic                 r_cmd_ready;
  logic                 r_rsp_valid;
  logic [MEM_WIDTH-1:0] r_rsp_data;
  logic                 r_rsp_perr;
  logic [7:0]           r_perr_count;
  logic                 r_ram_blk_sel;
  logic                 r_ram_addr_en;
  logic                 r_ram_wr_en;
  logic                 r_ram_rd_en;
  logic                 r_ram_dout_en;
  logic [ADDR_SIZE-1:0] r_ram_addr;
  logic [MEM_WIDTH-1:0] r_ram_din;

  logic                 w_accept;
  logic                 w_sample;
  logic                 w_perr;
  logic                 w_cmd_ready_nxt;
  logic                 w_rsp_valid_nxt;
  logic                 w_blk_sel_nxt;
  logic                 w_addr_en_nxt;
  logic                 w_wr_en_nxt;
  logic                 w_rd_en_nxt;
  logic                 w_dout_en_nxt;

  // cmd_ready is only ever high in IDLE, so this is an IDLE-state accept.
  assign w_accept = cmd_valid & r_cmd_ready;
  assign w_sample = (r_state == S_WAIT) && (r_lat_cnt == 3'd0);
  assign w_perr   = (PARITY_CHECK != 0) && ((^ram_dout) != ram_parity);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_blk_sel_nxt   = 1'b0;
    w_addr_en_nxt   = 1'b0;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_dout_en_nxt   = 1'b0;

    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      // ram_wr_en is high in ISSUE exactly when the command is a write.
      S_ISSUE: w_state_nxt = r_ram_wr_en ? S_IDLE : S_WAIT;
      S_WAIT:  if (r_lat_cnt == 3'd0) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == S_RESP);
    w_blk_sel_nxt   = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);
    w_addr_en_nxt   = (w_state_nxt == S_ISSUE);
    w_dout_en_nxt   = (w_state_nxt == S_WAIT);
    // ISSUE is entered only from an accept, so the strobes follow cmd_wr.
    w_wr_en_nxt     = w_accept &  cmd_wr;
    w_rd_en_nxt     = w_accept & ~cmd_wr;
  end

  // Read-latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat_cnt <= 3'd0;
    end else if (r_state == S_ISSUE) begin
      r_lat_cnt <= LAT_LOAD;
    end else if ((r_state == S_WAIT) && (r_lat_cnt != 3'd0)) begin
      r_lat_cnt <= r_lat_cnt - 3'd1;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_perr    <= 1'b0;
      r_perr_count  <= 8'd0;
      r_ram_blk_sel <= 1'b0;
      r_ram_addr_en <= 1'b0;
      r_ram_wr_en   <= 1'b0;
      r_ram_rd_en   <= 1'b0;
      r_ram_dout_en <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
    end else begin
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_ram_blk_sel <= w_blk_sel_nxt;
      r_ram_addr_en <= w_addr_en_nxt;
      r_ram_wr_en   <= w_wr_en_nxt;
      r_ram_rd_en   <= w_rd_en_nxt;
      r_ram_dout_en <= w_dout_en_nxt;
      if (w_accept) begin
        r_ram_addr <= cmd_addr;
        r_ram_din  <= cmd_data;
      end
      if (w_sample) begin
        r_rsp_data <= ram_dout;
        r_rsp_perr <= w_perr;
        if (w_perr) r_perr_count <= sat_inc8(r_perr_count);
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_perr    = r_rsp_perr;
  assign perr_count  = r_perr_count;
  assign ram_blk_sel = r_ram_blk_sel;
  assign ram_addr_en = r_ram_addr_en;
  assign ram_wr_en   = r_ram_wr_en;
  assign ram_rd_en   = r_ram_rd_en;
  assign ram_dout_en = r_ram_dout_en;
  assign ram_addr    = r_ram_addr;
  assign ram_din     = r_ram_din;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_access_ctrl
//   Directed bench for ram_access_ctrl. Instance A: RD_LATENCY=2, parity on.
//   Instance B: RD_LATENCY=1, parity off. Each has a small RAM model whose
//   parity pin can be forced wrong.
// -----------------------------------------------------------------------------
module tb_ram_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_cmd_valid, a_cmd_ready, a_cmd_wr;
  logic [9:0]  a_cmd_addr;
  logic [15:0] a_cmd_data;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_perr;
  logic [15:0] a_rsp_data;
  logic [7:0]  a_perr_count;
  logic        a_blk, a_aen, a_wen, a_ren, a_den;
  logic [9:0]  a_ram_addr;
  logic [15:0] a_ram_din, a_ram_dout;
  logic        a_ram_parity;

  // Instance B signals
  logic        b_cmd_valid, b_cmd_ready, b_cmd_wr;
  logic [9:0]  b_cmd_addr;
  logic [15:0] b_cmd_data;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_perr;
  logic [15:0] b_rsp_data;
  logic [7:0]  b_perr_count;
  logic        b_blk, b_aen, b_wen, b_ren, b_den;
  logic [9:0]  b_ram_addr;
  logic [15:0] b_ram_din, b_ram_dout;
  logic        b_ram_parity;

  ram_access_ctrl #(.MEM_WIDTH(16), .ADDR_SIZE(10), .RD_LATENCY(2), .PARITY_CHECK(1)) u_a (
    .clk(clk), .rst(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_wr(a_cmd_wr),
    .cmd_addr(a_cmd_addr), .cmd_data(a_cmd_data),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_perr(a_rsp_perr), .perr_count(a_perr_count),
    .ram_blk_sel(a_blk), .ram_addr_en(a_aen), .ram_wr_en(a_wen), .ram_rd_en(a_ren),
    .ram_dout_en(a_den), .ram_addr(a_ram_addr), .ram_din(a_ram_din),
    .ram_dout(a_ram_dout), .ram_parity(a_ram_parity)
  );

  ram_access_ctrl #(.MEM_WIDTH(16), .ADDR_SIZE(10), .RD_LATENCY(1), .PARITY_CHECK(0)) u_b (
    .clk(clk), .rst(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_wr(b_cmd_wr),
    .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_perr(b_rsp_perr), .perr_count(b_perr_count),
    .ram_blk_sel(b_blk), .ram_addr_en(b_aen), .ram_wr_en(b_wen), .ram_rd_en(b_ren),
    .ram_dout_en(b_den), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
    .ram_dout(b_ram_dout), .ram_parity(b_ram_parity)
  );

  // RAM models: data leaves the array at the rd_en edge, then an optional
  // output register gives the 2-cycle variant.
  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [1024];
  logic [15:0] a_p1, a_p2, b_p1;
  logic        force_a, force_b;

  always @(posedge clk) begin
    if (a_blk && a_wen) mem_a[a_ram_addr] <= a_ram_din;
    if (a_blk && a_ren) a_p1 <= mem_a[a_ram_addr];
    a_p2 <= a_p1;
    if (b_blk && b_wen) mem_b[b_ram_addr] <= b_ram_din;
    if (b_blk && b_ren) b_p1 <= mem_b[b_ram_addr];
  end

  assign a_ram_dout   = a_p2;
  assign a_ram_parity = (^a_ram_dout) ^ force_a;
  assign b_ram_dout   = b_p1;
  assign b_ram_parity = (^b_ram_dout) ^ force_b;

  int n_chk  = 0;
  int n_pass = 0;
  int both_hi = 0;

  always @(negedge clk) begin
    if ((a_wen && a_ren) || (b_wen && b_ren)) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] a_ctl();
    return {a_cmd_ready, a_rsp_valid, a_rsp_perr, a_blk, a_aen, a_wen, a_ren, a_den};
  endfunction

  function automatic logic [7:0] b_ctl();
    return {b_cmd_ready, b_rsp_valid, b_rsp_perr, b_blk, b_aen, b_wen, b_ren, b_den};
  endfunction

  // Read on A: lat = cycles from accept to rsp_valid (20 means it never came).
  task automatic rd_a(input logic [9:0] addr, output int lat,
                      output logic [15:0] data, output logic perr);
    a_cmd_valid = 1'b1; a_cmd_wr = 1'b0; a_cmd_addr = addr;
    step();
    a_cmd_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    data = a_rsp_data;
    perr = a_rsp_perr;
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
  endtask

  task automatic rd_b(input logic [9:0] addr, output int lat,
                      output logic [15:0] data, output logic perr);
    b_cmd_valid = 1'b1; b_cmd_wr = 1'b0; b_cmd_addr = addr;
    step();
    b_cmd_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    data = b_rsp_data;
    perr = b_rsp_perr;
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] d;
    logic        pe;
    int          vld_seen;

    rst = 1'b1;
    a_cmd_valid = 0; a_cmd_wr = 0; a_cmd_addr = '0; a_cmd_data = '0; a_rsp_ready = 0;
    b_cmd_valid = 0; b_cmd_wr = 0; b_cmd_addr = '0; b_cmd_data = '0; b_rsp_ready = 0;
    force_a = 0; force_b = 0;

    // Reset state
    repeat (3) step();
    check("rst_a_ctl", a_ctl(), 8'h00);
    check("rst_b_ctl", b_ctl(), 8'h00);
    check("rst_a_data", {a_ram_addr, a_ram_din, a_rsp_data}, 42'd0);
    check("rst_a_pcnt", a_perr_count, 8'd0);
    rst = 1'b0;
    step();
    check("rdy_after_rst_a", a_cmd_ready, 1'b1);
    check("rdy_after_rst_b", b_cmd_ready, 1'b1);

    // Write 0x005 = 0xA5A5
    a_cmd_valid = 1; a_cmd_wr = 1; a_cmd_addr = 10'h005; a_cmd_data = 16'hA5A5;
    step();
    a_cmd_valid = 0;
    check("wr_issue_ctl", a_ctl(), 8'b0001_1100);
    check("wr_issue_addr", a_ram_addr, 10'h005);
    check("wr_issue_din", a_ram_din, 16'hA5A5);
    step();
    check("wr_done_ctl", a_ctl(), 8'b1000_0000);

    // Read 0x005, cycle by cycle
    a_cmd_valid = 1; a_cmd_wr = 0; a_cmd_addr = 10'h005;
    step();
    a_cmd_valid = 0;
    check("rd_issue_ctl", a_ctl(), 8'b0001_1010);
    step();
    check("rd_wait1_ctl", a_ctl(), 8'b0001_0001);
    check("rd_wait_addr", a_ram_addr, 10'h005);
    step();
    check("rd_wait2_ctl", a_ctl(), 8'b0001_0001);
    step();
    check("rd_resp_ctl", a_ctl(), 8'b0100_0000);
    check("rd_resp_data", a_rsp_data, 16'hA5A5);
    a_rsp_ready = 1;
    step();
    a_rsp_ready = 0;
    check("rd_after_resp_ctl", a_ctl(), 8'b1000_0000);

    // Parity error and saturation of perr_count
    force_a = 1;
    rd_a(10'h005, lat, d, pe);
    check("perr_lat", lat, 4);
    check("perr_flag", pe, 1'b1);
    check("perr_data", d, 16'hA5A5);
    check("perr_cnt_1", a_perr_count, 8'd1);
    for (int i = 0; i < 254; i++) rd_a(10'h005, lat, d, pe);
    check("perr_cnt_255", a_perr_count, 8'd255);
    rd_a(10'h005, lat, d, pe);
    check("perr_cnt_sat", a_perr_count, 8'd255);
    force_a = 0;
    rd_a(10'h005, lat, d, pe);
    check("perr_clear_flag", pe, 1'b0);
    check("perr_clear_cnt", a_perr_count, 8'd255);

    // Response back-pressure; a command offered meanwhile must be ignored
    a_cmd_valid = 1; a_cmd_wr = 0; a_cmd_addr = 10'h005;
    step();
    a_cmd_valid = 0;
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    check("bp_lat", lat, 4);
    a_cmd_valid = 1; a_cmd_wr = 1; a_cmd_addr = 10'h3FF; a_cmd_data = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_ctl", a_ctl(), 8'b0100_0000);
      check("bp_hold_data", a_rsp_data, 16'hA5A5);
      step();
    end
    a_cmd_valid = 0;
    a_rsp_ready = 1;
    step();
    a_rsp_ready = 0;
    check("bp_release_ctl", a_ctl(), 8'b1000_0000);

    // Back-to-back writes at the address extremes with cmd_valid held
    a_cmd_valid = 1; a_cmd_wr = 1; a_cmd_addr = 10'h3FF; a_cmd_data = 16'h1234;
    step();
    check("b2b_w1_ctl", a_ctl(), 8'b0001_1100);
    check("b2b_w1_addr", a_ram_addr, 10'h3FF);
    a_cmd_addr = 10'h000; a_cmd_data = 16'hBEEF;
    step();
    check("b2b_gap_ctl", a_ctl(), 8'b1000_0000);
    step();
    a_cmd_valid = 0;
    check("b2b_w2_ctl", a_ctl(), 8'b0001_1100);
    check("b2b_w2_addr", a_ram_addr, 10'h000);
    check("b2b_w2_din", a_ram_din, 16'hBEEF);
    step();
    rd_a(10'h3FF, lat, d, pe);
    check("b2b_rd_3ff", d, 16'h1234);
    rd_a(10'h000, lat, d, pe);
    check("b2b_rd_000", d, 16'hBEEF);

    // RD_LATENCY=1, parity check disabled
    b_cmd_valid = 1; b_cmd_wr = 1; b_cmd_addr = 10'h012; b_cmd_data = 16'h0001;
    step();
    b_cmd_valid = 0;
    step();
    force_b = 1;
    rd_b(10'h012, lat, d, pe);
    check("l1_lat", lat, 3);
    check("l1_data", d, 16'h0001);
    check("l1_perr", pe, 1'b0);
    check("l1_pcnt", b_perr_count, 8'd0);
    force_b = 0;

    // Reset held 3 cycles while a read sits in WAIT
    a_cmd_valid = 1; a_cmd_wr = 0; a_cmd_addr = 10'h005;
    step();
    a_cmd_valid = 0;
    step();
    check("mid_rd_wait", a_den, 1'b1);
    rst = 1;
    repeat (3) step();
    check("mid_rst_ctl", a_ctl(), 8'h00);
    check("mid_rst_data", {a_ram_addr, a_ram_din, a_rsp_data}, 42'd0);
    check("mid_rst_pcnt", a_perr_count, 8'd0);
    rst = 0;
    step();
    check("mid_rst_rdy", a_cmd_ready, 1'b1);
    vld_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_rsp_valid) vld_seen++;
      step();
    end
    check("mid_rst_no_rsp", vld_seen, 0);

    check("wr_rd_exclusive", both_hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
